udp_frame_send: RTL and testbench



---
 rtl/udp_frame_send.sv | 225 ++++++++++++++++++++++
 tb/tb_udp_frame_send.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_frame_send.sv
// Streams a frame buffer out as UDP packets. Each packet is one line segment:
// fetch SEG_PIX pixels from DRAM into a FIFO, then send a header word followed by the pixels.
module udp_frame_send #(
    parameter int          X_SIZE  = 1600,
    parameter int          Y_SIZE  = 900,
    parameter int          SEG_PIX = 320,
    parameter logic [31:0] BASE0   = 32'h0000_0000,
    parameter logic [31:0] BASE1   = 32'h0080_0000,
    parameter int          GAP     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_select,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_addr,
    output logic [31:0] read_num,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    output logic        w_req,
    input  logic        w_ack,
    output logic        w_enable,
    output logic [31:0] w_data,
    output logic        frame_done,
    output logic        overflow
);

    localparam int            CW       = $clog2(SEG_PIX + 1);
    localparam int            AW       = (SEG_PIX > 1) ? $clog2(SEG_PIX) : 1;
    localparam logic [CW-1:0] SEG_CNT  = CW'(SEG_PIX);
    localparam logic [15:0]   SEG_STEP = 16'(SEG_PIX);
    localparam logic [15:0]   X_LIM    = 16'(X_SIZE);
    localparam logic [15:0]   Y_LIM    = 16'(Y_SIZE);
    localparam logic [15:0]   GAP_LAST = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    typedef enum logic [2:0] {IDLE, FETCH, REQ, SEND, GAPW} state_t;

    state_t        state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [15:0]   y_q, y_d;
    logic [15:0]   x_q, x_d;
    logic [3:0]    frame_cnt_q, frame_cnt_d;
    logic          kick_q, kick_d;
    logic          accepted_q, accepted_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] send_idx_q, send_idx_d;
    logic [15:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]   read_addr_q, read_addr_d;
    logic [31:0]   read_num_q, read_num_d;
    logic          w_req_q, w_req_d;
    logic          w_enable_q, w_enable_d;
    logic [31:0]   w_data_q, w_data_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    logic [31:0]   fifo_q [SEG_PIX];
    logic          fifo_we;
    logic [AW-1:0] fifo_waddr;
    logic          start_fetch;
    logic [15:0]   x_next, y_next;
    logic [31:0]   pix_off;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        base_d       = base_q;
        y_d          = y_q;
        x_d          = x_q;
        frame_cnt_d  = frame_cnt_q;
        kick_d       = kick_q;
        accepted_d   = accepted_q;
        cnt_d        = cnt_q;
        send_idx_d   = send_idx_q;
        gap_cnt_d    = gap_cnt_q;
        read_addr_d  = read_addr_q;
        read_num_d   = read_num_q;
        w_req_d      = w_req_q;
        w_enable_d   = 1'b0;
        w_data_d     = w_data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        fifo_we      = 1'b0;
        fifo_waddr   = cnt_q[AW-1:0];
        start_fetch  = 1'b0;
        x_next       = x_q + SEG_STEP;
        y_next       = y_q + 16'd1;

        // Only a FETCH with room left may store a word; anything else is lost and flagged.
        if (buf_we) begin
            if (state_q == FETCH && cnt_q != SEG_CNT) begin
                fifo_we = 1'b1;
                cnt_d   = cnt_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    base_d      = frame_select ? BASE1 : BASE0;
                    y_d         = '0;
                    x_d         = '0;
                    start_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (kick_q && busy) begin
                    accepted_d = 1'b1;
                    kick_d     = 1'b0;
                end
                if (accepted_q && !busy && cnt_q == SEG_CNT) begin
                    state_d = REQ;
                    w_req_d = 1'b1;
                end
            end
            REQ: begin
                if (w_req_q && w_ack) begin
                    w_req_d    = 1'b0;
                    w_enable_d = 1'b1;
                    w_data_d   = {4'hA, frame_cnt_q, y_q[11:0], x_q[11:0]};
                    send_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // send_idx_q counts words already on the bus; the header was word 0.
                if (send_idx_q != SEG_CNT) begin
                    w_enable_d = 1'b1;
                    w_data_d   = fifo_q[send_idx_q[AW-1:0]];
                    send_idx_d = send_idx_q + CW'(1);
                end else begin
                    cnt_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = GAPW;
                    if (x_next >= X_LIM) begin
                        x_d = '0;
                        y_d = y_next;
                        if (y_next == Y_LIM) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 4'd1;
                        end
                    end else begin
                        x_d = x_next;
                    end
                end
            end
            GAPW: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    if (y_q >= Y_LIM) state_d = IDLE;
                    else              start_fetch = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        pix_off = 32'(y_d) * 32'(X_SIZE) + 32'(x_d);
        if (start_fetch) begin
            state_d     = FETCH;
            kick_d      = 1'b1;
            accepted_d  = 1'b0;
            read_num_d  = 32'(SEG_PIX);
            read_addr_d = base_d + {pix_off[29:0], 2'b00};
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            y_q          <= '0;
            x_q          <= '0;
            frame_cnt_q  <= '0;
            kick_q       <= 1'b0;
            accepted_q   <= 1'b0;
            cnt_q        <= '0;
            send_idx_q   <= '0;
            gap_cnt_q    <= '0;
            read_addr_q  <= '0;
            read_num_q   <= '0;
            w_req_q      <= 1'b0;
            w_enable_q   <= 1'b0;
            w_data_q     <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            y_q          <= y_d;
            x_q          <= x_d;
            frame_cnt_q  <= frame_cnt_d;
            kick_q       <= kick_d;
            accepted_q   <= accepted_d;
            cnt_q        <= cnt_d;
            send_idx_q   <= send_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            read_addr_q  <= read_addr_d;
            read_num_q   <= read_num_d;
            w_req_q      <= w_req_d;
            w_enable_q   <= w_enable_d;
            w_data_q     <= w_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: the FIFO array is not reset; clearing the occupancy counter empties it, so stale words are never read.
    always_ff @(posedge clk) begin
        if (fifo_we) fifo_q[fifo_waddr] <= buf_dout;
    end

    assign kick       = kick_q;
    assign read_addr  = read_addr_q;
    assign read_num   = read_num_q;
    assign w_req      = w_req_q;
    assign w_enable   = w_enable_q;
    assign w_data     = w_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_udp_frame_send.sv
// Directed bench for udp_frame_send on an 8x2 frame with 4-pixel packets, using a
// DRAM responder, a delayed UDP grant and a negedge monitor that logs kicks and packet words.
module tb_udp_frame_send;

    localparam int          X_SZ = 8;
    localparam int          Y_SZ = 2;
    localparam int          SEG  = 4;
    localparam int          GP   = 2;
    localparam logic [31:0] B0   = 32'h0000_0100;
    localparam logic [31:0] B1   = 32'h0080_0000;

    logic        clk, rst_n, enable, frame_select;
    logic        kick, busy, buf_we, w_req, w_ack, w_enable, frame_done, overflow;
    logic [31:0] read_addr, read_num, buf_dout, w_data;

    udp_frame_send #(
        .X_SIZE(X_SZ), .Y_SIZE(Y_SZ), .SEG_PIX(SEG), .BASE0(B0), .BASE1(B1), .GAP(GP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_select(frame_select),
        .kick(kick), .busy(busy), .read_addr(read_addr), .read_num(read_num),
        .buf_dout(buf_dout), .buf_we(buf_we), .w_req(w_req), .w_ack(w_ack),
        .w_enable(w_enable), .w_data(w_data), .frame_done(frame_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] kick_addr_q [$];
    logic [31:0] kick_num_q  [$];
    logic [31:0] word_q      [$];
    logic [31:0] dram_q      [$];
    int          en_runs     [$];
    int          req_runs    [$];
    int          fd_count;
    int          en_len, req_len;
    logic        kick_prev;
    int          ack_wait = 2;
    logic        extra_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        return (i < word_q.size()) ? word_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] dram_at(input int i);
        return (i < dram_q.size()) ? dram_q[i] : (32'hBAD0_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] kick_at(input int i);
        return (i < kick_addr_q.size()) ? kick_addr_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_logs();
        kick_addr_q.delete();
        kick_num_q.delete();
        word_q.delete();
        dram_q.delete();
        en_runs.delete();
        req_runs.delete();
        fd_count = 0;
    endtask

    // Packet p in the word log: header, then the p-th group of four DRAM words.
    task automatic check_packet(input string tag, input int p, input logic [31:0] hdr);
        check($sformatf("%s_hdr", tag), word_at(5 * p), hdr);
        for (int k = 0; k < SEG; k++)
            check($sformatf("%s_d%0d", tag, k), word_at(5 * p + 1 + k), dram_at(SEG * p + k));
    endtask

    task automatic wait_runs(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && en_runs.size() < n; i++) @(posedge clk);
        #1;
        check(tag, 32'(en_runs.size() >= n), 32'd1);
    endtask

    task automatic wait_fd(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && fd_count < n; i++) @(posedge clk);
        #1;
        check(tag, 32'(fd_count >= n), 32'd1);
    endtask

    task automatic wait_kicks(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && kick_addr_q.size() < n; i++) @(posedge clk);
        #1;
        check(tag, 32'(kick_addr_q.size() >= n), 32'd1);
    endtask

    // DRAM reader: take a kick, stay busy, return four words (five when extra_we is armed).
    initial begin
        logic [31:0] word_seq;
        int          n;
        word_seq = 32'hC0DE_0001;
        busy     = 1'b0;
        buf_we   = 1'b0;
        buf_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && kick && !busy) begin
                busy = 1'b1;
                @(posedge clk); #1;
                n        = extra_we ? SEG + 1 : SEG;
                extra_we = 1'b0;
                for (int i = 0; i < n; i++) begin
                    buf_we   = 1'b1;
                    buf_dout = word_seq;
                    if (i < SEG) dram_q.push_back(word_seq);
                    word_seq = word_seq + 32'h0103_0507;
                    @(posedge clk); #1;
                end
                buf_we = 1'b0;
                busy   = 1'b0;
            end
        end
    end

    // UDP side: grant in the ack_wait-th cycle that w_req is seen high.
    initial begin
        int req_seen;
        req_seen = 0;
        w_ack    = 1'b0;
        forever begin
            @(posedge clk); #1;
            w_ack = 1'b0;
            if (rst_n && w_req) begin
                req_seen++;
                if (req_seen == ack_wait) begin
                    w_ack    = 1'b1;
                    req_seen = 0;
                end
            end else begin
                req_seen = 0;
            end
        end
    end

    initial begin
        kick_prev = 1'b0;
        en_len    = 0;
        req_len   = 0;
        fd_count  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_len    = 0;
                req_len   = 0;
                kick_prev = 1'b0;
            end else begin
                if (kick && !kick_prev) begin
                    kick_addr_q.push_back(read_addr);
                    kick_num_q.push_back(read_num);
                end
                kick_prev = kick;
                if (w_enable) begin
                    word_q.push_back(w_data);
                    en_len++;
                end else if (en_len > 0) begin
                    en_runs.push_back(en_len);
                    en_len = 0;
                end
                if (w_req) req_len++;
                else if (req_len > 0) begin
                    req_runs.push_back(req_len);
                    req_len = 0;
                end
                if (frame_done) fd_count++;
            end
        end
    end

    initial begin
        logic [31:0] hdr_a [4];
        logic [31:0] off   [4];
        int          seen;
        hdr_a = '{32'h0000_0000, 32'h0000_0004, 32'h0000_1000, 32'h0000_1004};
        off   = '{32'h00, 32'h10, 32'h20, 32'h30};

        rst_n        = 1'b0;
        enable       = 1'b0;
        frame_select = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_kick",       32'(kick),       32'd0);
        check("rst_w_req",      32'(w_req),      32'd0);
        check("rst_w_enable",   32'(w_enable),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_read_addr",  read_addr,       32'd0);
        check("rst_read_num",   read_num,        32'd0);
        check("rst_w_data",     w_data,          32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_kick", 32'(kick), 32'd0);

        // Full frame from BASE0; enable drops after the first packet but the frame completes.
        clear_logs();
        enable = 1'b1;
        wait_runs("t2_first_pkt", 1, 300);
        enable = 1'b0;
        wait_fd("t2_frame_done", 1, 600);
        repeat (40) @(posedge clk);
        #1;
        check("t2_kick_count", 32'(kick_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), kick_at(i), B0 + off[i]);
            check($sformatf("t2_num%0d", i), (i < kick_num_q.size()) ? kick_num_q[i] : 32'hx, 32'd4);
            check_packet($sformatf("t2_pkt%0d", i), i, 32'hA000_0000 | hdr_a[i]);
            check($sformatf("t2_run%0d", i), 32'((i < en_runs.size()) ? en_runs[i] : 0), 32'd5);
        end
        check("t2_word_count", 32'(word_q.size()), 32'd20);
        check("t2_fd_pulses",  32'(fd_count),      32'd1);
        check("t2_stays_idle", 32'(kick),          32'd0);

        // Slow grant; frame_select flips mid-frame and only the next frame uses BASE1.
        clear_logs();
        ack_wait = 10;
        enable   = 1'b1;
        wait_kicks("t3_first_kick", 1, 100);
        frame_select = 1'b1;
        wait_fd("t3_frame_a", 1, 1000);
        wait_kicks("t3_frame_b_kick", 5, 200);
        enable = 1'b0;
        wait_fd("t3_frame_b", 2, 1000);
        repeat (10) @(posedge clk);
        #1;
        frame_select = 1'b0;
        check("t3_kick_count", 32'(kick_addr_q.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_addr_a%0d", i), kick_at(i),     B0 + off[i]);
            check($sformatf("t3_addr_b%0d", i), kick_at(i + 4), B1 + off[i]);
            check_packet($sformatf("t3_pkt_a%0d", i), i,     32'hA100_0000 | hdr_a[i]);
            check_packet($sformatf("t3_pkt_b%0d", i), i + 4, 32'hA200_0000 | hdr_a[i]);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_req_len%0d", i), 32'((i < req_runs.size()) ? req_runs[i] : 0), 32'd10);
            check($sformatf("t3_en_len%0d", i),  32'((i < en_runs.size())  ? en_runs[i]  : 0), 32'd5);
        end

        // Five words answer the first kick: the fifth is dropped and overflow sticks.
        clear_logs();
        ack_wait = 2;
        extra_we = 1'b1;
        enable   = 1'b1;
        @(posedge clk);
        #1;
        check("t4_ovf_before", 32'(overflow), 32'd0);
        wait_runs("t4_first_pkt", 1, 300);
        enable = 1'b0;
        check("t4_ovf_set", 32'(overflow), 32'd1);
        wait_fd("t4_frame_done", 1, 600);
        repeat (5) @(posedge clk);
        #1;
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++)
            check_packet($sformatf("t4_pkt%0d", i), i, 32'hA300_0000 | hdr_a[i]);
        check("t4_word_count", 32'(word_q.size()), 32'd20);

        // Reset while word 2 of the first packet is on the bus.
        clear_logs();
        enable = 1'b1;
        seen   = 0;
        for (int i = 0; i < 300 && seen < 3; i++) begin
            @(posedge clk); #2;
            if (w_enable) seen++;
        end
        check("t5_reached_word2", 32'(seen), 32'd3);
        check("t5_word2_data", w_data, dram_at(1));
        rst_n = 1'b0;
        #1;
        check("t5_rst_w_enable", 32'(w_enable), 32'd0);
        check("t5_rst_kick",     32'(kick),     32'd0);
        check("t5_rst_w_req",    32'(w_req),    32'd0);
        check("t5_rst_w_data",   w_data,        32'd0);
        check("t5_rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
        wait_runs("t5_first_pkt", 1, 300);
        enable = 1'b0;
        check("t5_fresh_addr", kick_at(0), B0);
        check_packet("t5_pkt0", 0, 32'hA000_0000);
        check("t5_run0", 32'((en_runs.size() > 0) ? en_runs[0] : 0), 32'd5);
        wait_fd("t5_frame_done", 1, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
